// File: rtl/adc_parallel_responder.sv
// Stand-in for the external 8-bit parallel ADC: BUSY for CONV_CYCLES after a CONVST rising edge, then a synthetic sample is readable on D.
// Latency: BUSY rises one edge after start, new data CONV_CYCLES edges later; read data/DOE are registered (1 cycle). No backpressure; starts during BUSY are dropped and flagged.
// Optional feature: define ADC_RESP_NOISE_EN to XOR LFSR noise into sample bits [1:0].
module adc_parallel_responder #(
    parameter int CONV_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        adcRst,
    input  logic        CONVST,
    input  logic        CS,
    input  logic        RD,
    input  logic [1:0]  shapeSel,
    input  logic [2:0]  stepSel,
    input  logic [7:0]  level,
    output logic        BUSY,
    output logic [7:0]  D,
    output logic        DOE,
    output logic        overrun,
    output logic [15:0] convCount
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic        convst_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  phase_q, phase_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] count_q, count_d;
    logic        ovr_q, ovr_d;
    logic        doe_q;
    logic [7:0]  d_q;
    logic        start;
    logic        rd_en;
    logic [7:0]  sample;
    logic [7:0]  store_val;

    assign start = CONVST & ~convst_q;
    assign rd_en = ~CS & ~RD;

    always_comb begin
        sample = phase_q;
        case (shapeSel)
            2'd0: sample = phase_q;
            2'd1: sample = phase_q[7] ? {~phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
            2'd2: sample = phase_q[7] ? 8'hFF : 8'h00;
            2'd3: sample = level;
            default: sample = phase_q;
        endcase
    end

`ifdef ADC_RESP_NOISE_EN
    logic [7:0] lfsr_q;
    logic       do_complete;

    assign do_complete = (state_q == CONV) && (cnt_q == 8'd0);
    assign store_val   = sample ^ {6'b0, lfsr_q[1:0]};

    // Fibonacci form of x^8+x^6+x^5+x^4+1, stepped once per finished conversion.
    always_ff @(posedge Clk or negedge adcRst) begin
        if (!adcRst) begin
            lfsr_q <= 8'h01;
        end else if (do_complete) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
`else
    assign store_val = sample;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        data_d  = data_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    cnt_d   = 8'(CONV_CYCLES - 1);
                end
            end
            CONV: begin
                if (start) ovr_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    data_d  = store_val;
                    phase_d = phase_q + (8'd1 << stepSel);
                    count_d = count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // convst_q resets high so a CONVST held through reset release is not an edge.
    always_ff @(posedge Clk or negedge adcRst) begin
        if (!adcRst) begin
            state_q  <= IDLE;
            convst_q <= 1'b1;
            cnt_q    <= 8'd0;
            phase_q  <= 8'd0;
            data_q   <= 8'd0;
            count_q  <= 16'd0;
            ovr_q    <= 1'b0;
            doe_q    <= 1'b0;
            d_q      <= 8'd0;
        end else begin
            state_q  <= state_d;
            convst_q <= CONVST;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            data_q   <= data_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            doe_q    <= rd_en;
            d_q      <= rd_en ? data_q : 8'h00;
        end
    end

    assign BUSY      = (state_q == CONV);
    assign D         = d_q;
    assign DOE       = doe_q;
    assign overrun   = ovr_q;
    assign convCount = count_q;

endmodule
